// File: rtl/vxe_pipe_pkg.sv
// Shared defaults and width helper for the VxEngine elastic delay pipe.
package vxe_pipe_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NSTAGES    = 5;

  // Counter must represent 0..nstages inclusive.
  function automatic int cnt_width(input int nstages);
    return $clog2(nstages + 1);
  endfunction
endpackage

// File: rtl/vxe_pipe_stage.sv
// One elastic pipe stage: a valid bit plus payload register, advanced by the ready chain.
module vxe_pipe_stage
  import vxe_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  flush_i,
  input  logic                  adv_i,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  vld_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic                  vld_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Payload only moves with a valid token, so bubbles never disturb held data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (flush_i) begin
      vld_q  <= 1'b0;
    end else if (adv_i) begin
      vld_q <= vld_i;
      if (vld_i) data_q <= data_i;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
endmodule

// File: rtl/vxe_pipe_3.sv
// Elastic ready/valid delay line with bubble collapse, synchronous flush and occupancy count.
module vxe_pipe_3
  import vxe_pipe_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int NSTAGES    = DEF_NSTAGES,
  localparam int CNT_WIDTH  = cnt_width(NSTAGES)
) (
  input  logic                  clk,
  input  logic                  nrst,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_count,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_vld,
  output logic                  o_rdy,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_vld,
  input  logic                  i_rdy
);
  logic [NSTAGES-1:0]                 v;
  logic [NSTAGES-1:0]                 adv;
  logic [NSTAGES-1:0][DATA_WIDTH-1:0] d;
  logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
  logic                               in_xfer, out_xfer;

  // A stage may move when it is empty or its successor moves; no skid buffer.
  always_comb begin
    adv = '0;
    adv[NSTAGES-1] = !v[NSTAGES-1] | i_rdy;
    for (int k = NSTAGES - 2; k >= 0; k--) adv[k] = !v[k] | adv[k+1];
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    logic                  vin;
    logic [DATA_WIDTH-1:0] din;
    if (k == 0) begin : g_head
      assign vin = i_vld;
      assign din = i_data;
    end else begin : g_body
      assign vin = v[k-1];
      assign din = d[k-1];
    end
    vxe_pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
      .clk     (clk),
      .nrst    (nrst),
      .flush_i (i_flush),
      .adv_i   (adv[k]),
      .vld_i   (vin),
      .data_i  (din),
      .vld_o   (v[k]),
      .data_o  (d[k])
    );
  end

  assign in_xfer  = i_vld & adv[0];
  assign out_xfer = v[NSTAGES-1] & i_rdy;

  always_comb begin
    cnt_d = cnt_q;
    if (i_flush)                  cnt_d = '0;
    else if (in_xfer & !out_xfer) cnt_d = cnt_q + CNT_WIDTH'(1);
    else if (out_xfer & !in_xfer) cnt_d = cnt_q - CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_rdy   = adv[0];
  assign o_vld   = v[NSTAGES-1];
  assign o_data  = d[NSTAGES-1];
  assign o_busy  = |v;
  assign o_count = cnt_q;
endmodule

// File: tb/tb_vxe_pipe_3.sv
// Bench for vxe_pipe_3: queue-of-items position model checked every cycle plus directed literals.
module tb_vxe_pipe_3;
  localparam int DW = 32;
  localparam int NS = 5;
  localparam int CW = $clog2(NS + 1);

  logic          clk = 1'b0, nrst = 1'b0;
  logic          i_flush = 1'b0, i_vld = 1'b0, i_rdy = 1'b1;
  logic [DW-1:0] i_data = '0;
  logic          o_busy, o_rdy, o_vld;
  logic [CW-1:0] o_count;
  logic [DW-1:0] o_data;

  always #5 clk = ~clk;

  vxe_pipe_3 dut (
    .clk(clk), .nrst(nrst), .o_busy(o_busy), .o_count(o_count), .i_flush(i_flush),
    .i_data(i_data), .i_vld(i_vld), .o_rdy(o_rdy), .o_data(o_data), .o_vld(o_vld), .i_rdy(i_rdy)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: ordered items, each with a position 0..NS-1 (NS-1 = output slot).
  typedef struct { logic [DW-1:0] d; int pos; } item_t;
  typedef int iq_t[$];
  item_t mq[$];

  // Oldest item leaves from the output slot if downstream is ready; every other
  // item steps forward one slot but can never land on or pass the item ahead.
  function automatic iq_t moves(input logic rdy);
    iq_t np;
    int  lim = NS - 1;
    foreach (mq[i]) begin
      int p;
      if (i == 0 && mq[i].pos == NS - 1 && rdy) p = NS;
      else p = (mq[i].pos + 1 < lim) ? mq[i].pos + 1 : lim;
      np.push_back(p);
      lim = p - 1;
    end
    return np;
  endfunction

  function automatic logic m_rdy(input logic rdy);
    iq_t np;
    if (mq.size() == 0) return 1'b1;
    np = moves(rdy);
    return np[np.size()-1] >= 1;
  endfunction

  always @(posedge clk or negedge nrst) begin
    logic acc;
    iq_t  np;
    if (!nrst) mq.delete();
    else if (i_flush) mq.delete();
    else begin
      acc = i_vld && m_rdy(i_rdy);
      np  = moves(i_rdy);
      for (int i = np.size() - 1; i >= 0; i--)
        if (np[i] == NS) mq.delete(i);
        else mq[i].pos = np[i];
      if (acc) mq.push_back('{i_data, 0});
    end
  end

  logic [DW-1:0] out_d[$];
  int            out_c[$];
  int            refused = 0, rdy_low = 0, peak = 0, bcnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] dat);
    int n = 0;
    i_vld  = 1'b1;
    i_data = dat;
    #1;
    while (!o_rdy && n < 50) begin
      tick();
      n++;
    end
    chk("send_bound", n < 50, 1);
    tick();
  endtask

  task automatic lat(output int n);
    n = 0;
    while (!o_vld && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_out(input string nm, input logic [DW-1:0] base, input int num);
    chk({nm, "_n"}, out_d.size(), num);
    for (int i = 0; i < num && i < out_d.size(); i++) chk(nm, out_d[i], base + DW'(i + 1));
  endtask

  initial begin
    int n;
    int idx;
    fork
      begin : mon
        logic ev;
        forever begin
          @(negedge clk);
          if (nrst) begin
            ev = mq.size() > 0 && mq[0].pos == NS - 1;
            chk("m_vld", o_vld, ev);
            chk("m_rdy", o_rdy, m_rdy(i_rdy));
            chk("m_count", o_count, mq.size());
            chk("m_busy", o_busy, mq.size() > 0);
            if (ev) chk("m_data", o_data, mq[0].d);
            if (o_vld && i_rdy && !i_flush) begin
              out_d.push_back(o_data);
              out_c.push_back(cyc);
            end
            if (i_vld && !o_rdy) refused++;
            if (!o_rdy) rdy_low++;
            if (int'(o_count) > peak) peak = int'(o_count);
            if (o_busy) bcnt++;
          end
        end
      end
    join_none

    // Reset state
    #12;
    chk("rst_vld", o_vld, 0);
    chk("rst_data", o_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_count", o_count, 0);
    chk("rst_rdy", o_rdy, 1);
    tick();
    nrst = 1'b1;

    // Single item
    bcnt = 0; out_d.delete();
    send(32'hBEEF0001);
    i_vld = 1'b0;
    chk("t1_count1", o_count, 1);
    lat(n);
    chk("t1_lat", n, NS - 1);
    chk("t1_data", o_data, 32'hBEEF0001);
    tick();
    chk("t1_vld_once", o_vld, 0);
    chk("t1_count0", o_count, 0);
    repeat (3) tick();
    chk("t1_busy_cycles", bcnt, 5);

    // Burst with downstream always ready
    out_d.delete(); out_c.delete(); peak = 0; rdy_low = 0;
    for (int i = 1; i <= 6; i++) send(32'hBEEF0000 + DW'(i));
    i_vld = 1'b0;
    repeat (10) tick();
    chk_out("t2_out", 32'hBEEF0000, 6);
    if (out_c.size() == 6) chk("t2_span", out_c[5] - out_c[0], 5);
    chk("t2_peak", peak, 5);
    chk("t2_rdy_low", rdy_low, 0);

    // Stall and pack, then release
    out_d.delete();
    i_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) send(32'hBEEF0000 + DW'(i));
    i_vld = 1'b1; i_data = 32'hBEEF0006;
    #1;
    chk("t3_full_rdy", o_rdy, 0);
    chk("t3_count", o_count, 5);
    chk("t3_vld", o_vld, 1);
    chk("t3_data", o_data, 32'hBEEF0001);
    repeat (3) tick();
    chk("t3_hold", o_data, 32'hBEEF0001);
    i_rdy = 1'b1;
    send(32'hBEEF0006);
    i_vld = 1'b0;
    repeat (10) tick();
    chk_out("t3_out", 32'hBEEF0000, 6);

    // Bubble collapse: sparse input under an 8-cycle stall
    out_d.delete(); refused = 0; idx = 0;
    for (int c = 0; c < 12; c++) begin
      i_rdy = (c >= 8);
      if (c == 8) chk("t4_count", o_count, 4);
      if (c % 2 == 0 && idx < 6) begin
        idx++;
        i_vld = 1'b1; i_data = 32'hBEEF0000 + DW'(idx);
      end else i_vld = 1'b0;
      tick();
    end
    i_vld = 1'b0;
    repeat (12) tick();
    chk("t4_refused", refused, 0);
    chk_out("t4_out", 32'hBEEF0000, 6);

    // Flush with an input presented in the same cycle
    out_d.delete();
    for (int i = 1; i <= 3; i++) send(32'hBEEF00A0 + DW'(i));
    i_flush = 1'b1; i_vld = 1'b1; i_data = 32'hBEEF00FF;
    tick();
    i_flush = 1'b0; i_vld = 1'b0;
    chk("t5_vld", o_vld, 0);
    chk("t5_count", o_count, 0);
    chk("t5_busy", o_busy, 0);
    repeat (10) tick();
    chk("t5_no_out", out_d.size(), 0);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("t5_empty_flush_rdy", o_rdy, 1);

    // Async reset mid-burst
    for (int i = 1; i <= 7; i++) send(32'hBEEF0010 + DW'(i));
    #1 nrst = 1'b0;
    #1;
    chk("t6_vld", o_vld, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_count", o_count, 0);
    chk("t6_data", o_data, 0);
    #1 nrst = 1'b1;
    i_vld = 1'b0;
    tick();
    out_d.delete();
    send(32'hBEEF0042);
    i_vld = 1'b0;
    lat(n);
    chk("t6_lat", n, NS - 1);
    chk("t6_out", o_data, 32'hBEEF0042);
    repeat (3) tick();
    chk("t6_one_out", out_d.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vxe_pipe_3.md
Name: vxe_pipe_3

Overview:
- Elastic, parametrised data pipe: successor to the fixed-latency valid-only pipe.
- Adds downstream backpressure (ready/valid on both sides), bubble collapsing, synchronous flush and an occupancy count.
- Used wherever VxEngine datapath stages need a configurable-depth delay line that can stall without losing data.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1).
- NSTAGES, 5, number of register stages (>=1).
- CNT_WIDTH, $clog2(NSTAGES+1), width of o_count (derived localparam, not overridable).

Ports:
- clk  in  1  clock; all state updates on posedge.
- nrst  in  1  reset, asynchronous, active-low.
- o_busy  out  1  high when any stage holds valid data.
- o_count  out  CNT_WIDTH  number of valid stages.
- i_flush  in  1  synchronous flush; discards all stage contents.
- i_data  in  DATA_WIDTH  upstream payload.
- i_vld  in  1  upstream valid.
- o_rdy  out  1  pipe can accept upstream data this cycle.
- o_data  out  DATA_WIDTH  payload of last stage.
- o_vld  out  1  last stage valid.
- i_rdy  in  1  downstream ready.

Behaviour:
- Reset (nrst=0, async): all stage valids=0, all stage data=0, so o_vld=0, o_data=0, o_busy=0, o_count=0. o_rdy=1 combinationally once valids are clear.
- Stages are indexed 0 (input) to NSTAGES-1 (output). Each stage has v[k] and d[k].
- Advance rule (combinational):
  - adv[NSTAGES-1] = !v[NSTAGES-1] | i_rdy.
  - adv[k] = !v[k] | adv[k+1] for k < NSTAGES-1.
  - o_rdy = adv[0]. The ready chain is purely combinational; there is no skid buffer.
- On posedge with adv[k]:
  - v[k] <= (k==0 ? i_vld : v[k-1]).
  - d[k] loads only when the incoming valid is 1; otherwise d[k] holds.
- Stage k with adv[k]=0 holds both v[k] and d[k].
- Handshakes:
  - Input transfer = i_vld & o_rdy.
  - Output transfer = o_vld & i_rdy.
  - o_vld/o_data are stable while o_vld=1 and i_rdy=0.
- Latency: with no stall, data accepted at edge t is visible on o_data/o_vld after edge t+NSTAGES-1, i.e. NSTAGES cycles from presentation. Throughput is 1 per cycle.
- Bubble collapse: an empty stage accepts from its predecessor even while downstream is stalled. With a stall long enough, the pipe packs to NSTAGES entries.
- Full: all v=1 and i_rdy=0 gives o_rdy=0. With i_rdy=1 while full, o_rdy=1, so an input and an output transfer happen in the same cycle.
- Flush: i_flush=1 at an edge clears all v to 0 and has priority over every transfer in that cycle. Data regs hold. o_rdy is not gated by i_flush, so an input presented in the flush cycle is dropped. A flush on an empty pipe is a no-op.
- o_count: registered, 0..NSTAGES.
  - Updates by +1 on an input transfer only, -1 on an output transfer only, 0 on both or neither.
  - Forced to 0 on flush.
  - Must always equal the popcount of v.
- o_busy = |v, combinational from the registers.
- Reset mid-operation: all contents are lost immediately, with no output glitch requirement beyond the async clear.
- NSTAGES=1: a single register with o_rdy = !v[0] | i_rdy.

Decomposition:
- Package vxe_pipe_pkg holds:
  - the default DATA_WIDTH/NSTAGES constants;
  - a function computing CNT_WIDTH;
  - no typedefs are required.
- One sub-module, vxe_pipe_stage: a single valid/data register with an adv input, instantiated NSTAGES times via generate.
- Count logic and ready chain live in the top module.

Test Plan:
- Single item, i_rdy=1: i_vld=1 with 0xBEEF0001 for 1 cycle → o_vld=1 for exactly 1 cycle, 5 cycles later, o_data=0xBEEF0001; o_busy high for 5 cycles; o_count 1 then 0.
- Burst, i_rdy=1: 0xBEEF0001..0006 on consecutive cycles → same values out on 6 consecutive cycles in order; o_count peaks at 5; o_rdy stays 1 throughout.
- Stall and pack: i_rdy=0, present 0xBEEF0001..0006 → first 5 accepted, o_rdy=0 on the 6th, o_count=5, o_data=0xBEEF0001 held. Then i_rdy=1 → 0001..0006 drain back-to-back with no loss or duplication.
- Bubble collapse: inputs every other cycle (0001..0006), i_rdy=0 for the first 8 cycles → no input is refused until 5 entries are held, and output order is preserved after release.
- Flush: 3 items in flight, assert i_flush with i_vld=1 (0xBEEF00FF) → next cycle o_vld=0, o_count=0, o_busy=0; 0xBEEF00FF never appears at the output.
- Async reset mid-burst: drop nrst between edges → o_vld, o_busy and o_count go to 0 immediately. After release, a single item still has 5-cycle latency.
